// File: rtl/multi_fl_pkg.sv
// rtl/multi_fl_pkg.sv - shared widths, counter limits and FSM state type for multi_fl
package multi_fl_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 6;

    // Count value seen during the 32nd (last possible) iteration
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_W - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mul_abs32.sv
// rtl/mul_abs32.sv - 32-bit two's-complement magnitude with unsigned result
module mul_abs32
    import multi_fl_pkg::*;
(
    input  logic [MUL_W-1:0] val,
    output logic [MUL_W-1:0] mag
);

    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    always_comb begin
        mag = val[MUL_W-1] ? (~val + 1'b1) : val;
    end

endmodule

// File: rtl/multi_fl.sv
// rtl/multi_fl.sv - sequential signed 32x32->64 shift-add multiplier, optional early termination
module multi_fl
    import multi_fl_pkg::*;
#(
    parameter int EARLY_TERM = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [MUL_W-1:0]  mlier,
    input  logic [MUL_W-1:0]  mcand,
    output logic [PROD_W-1:0] prodt,
    input  logic              start,
    output logic              valid
);

    state_e              state_q, state_d;
    logic                start_q, start_d;
    logic [MUL_W-1:0]    mlier_q, mlier_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [PROD_W-1:0]   prodt_q, prodt_d;
    logic                valid_q, valid_d;

    logic [MUL_W-1:0]    mlier_mag;
    logic [MUL_W-1:0]    mcand_mag;
    logic                capture;
    logic                last_iter;
    logic [MUL_W-1:0]    mlier_shr;
    logic [PROD_W-1:0]   acc_sum;

    mul_abs32 u_abs_mlier (.val(mlier), .mag(mlier_mag));
    mul_abs32 u_abs_mcand (.val(mcand), .mag(mcand_mag));

    // Iteration arithmetic and the finish decision for the current BUSY cycle
    always_comb begin
        capture   = (state_q == ST_IDLE) && start && !start_q;
        mlier_shr = mlier_q >> 1;
        acc_sum   = acc_q + (mlier_q[0] ? mcand_q : '0);
        last_iter = (cnt_q == CNT_LAST) || ((EARLY_TERM != 0) && (mlier_shr == '0));
    end

    // State register plus all datapath flops; reset aborts any operation in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            mlier_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            prodt_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            mlier_q <= mlier_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            prodt_q <= prodt_d;
            valid_q <= valid_d;
        end
    end

    // Next state: a start rising edge launches, the final iteration returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture)   state_d = ST_BUSY;
            ST_BUSY: if (last_iter) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Datapath updates: latch magnitudes on capture, shift-add while busy, sign-fix on the last step
    always_comb begin
        start_d = start;
        mlier_d = mlier_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        prodt_d = prodt_q;
        valid_d = 1'b0;
        if (capture) begin
            mlier_d = mlier_mag;
            mcand_d = {{(PROD_W-MUL_W){1'b0}}, mcand_mag};
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = mlier[MUL_W-1] ^ mcand[MUL_W-1];
        end else if (state_q == ST_BUSY) begin
            mlier_d = mlier_shr;
            mcand_d = mcand_q << 1;
            acc_d   = acc_sum;
            cnt_d   = cnt_q + 1'b1;
            if (last_iter) begin
                // Negating a zero accumulator yields zero, so no negative zero can appear
                prodt_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
                valid_d = 1'b1;
            end
        end
    end

    assign prodt = prodt_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_multi_fl.sv
// tb/tb_multi_fl.sv - directed and random checks of both multi_fl builds side by side
module tb_multi_fl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mlier = '0;
    logic [31:0] mcand = '0;
    logic        start = 1'b0;
    logic [63:0] prodt_f, prodt_v;
    logic        valid_f, valid_v;

    int errors = 0;
    int checks = 0;

    multi_fl #(.EARLY_TERM(0)) dut_f (
        .clock(clock), .reset(reset), .mlier(mlier), .mcand(mcand),
        .prodt(prodt_f), .start(start), .valid(valid_f)
    );

    multi_fl #(.EARLY_TERM(1)) dut_v (
        .clock(clock), .reset(reset), .mlier(mlier), .mcand(mcand),
        .prodt(prodt_v), .start(start), .valid(valid_v)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int model_lat(input logic [31:0] m);
        logic [31:0] mag;
        int          l;
        mag = m[31] ? (~m + 32'd1) : m;
        l = 1;
        for (int i = 0; i < 32; i++)
            if (mag[i]) l = i + 1;
        return l;
    endfunction

    // Drop start for low_cycles edges, present operands, raise start and pass the capture edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input int low_cycles);
        @(negedge clock);
        start = 1'b0;
        repeat (low_cycles) @(negedge clock);
        mlier = a;
        mcand = b;
        start = 1'b1;
        @(posedge clock);
    endtask

    // Watch 40 edges after capture with start held high; expect one pulse per build
    task automatic collect(input string name, input logic [63:0] exp, input int exp_lat_v,
                           input bit scramble);
        int lat_f = 0;
        int lat_v = 0;
        int n_f = 0;
        int n_v = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clock);
            #1;
            if (valid_f) begin n_f++; if (lat_f == 0) lat_f = cyc; end
            if (valid_v) begin n_v++; if (lat_v == 0) lat_v = cyc; end
            if (scramble && cyc == 1) begin
                mlier = ~mlier;
                mcand = $urandom;
            end
            if (scramble && exp_lat_v >= 6 && cyc == 3) start = 1'b0;
            if (scramble && exp_lat_v >= 6 && cyc == 4) start = 1'b1;
        end
        check64({name, "_prod_fixed"}, prodt_f, exp);
        check64({name, "_prod_var"}, prodt_v, exp);
        check_int({name, "_lat_fixed"}, lat_f, 32);
        check_int({name, "_lat_var"}, lat_v, exp_lat_v);
        check_int({name, "_pulses_fixed"}, n_f, 1);
        check_int({name, "_pulses_var"}, n_v, 1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        longint      ref_p;
        int          n_f, n_v;

        vecs[0] = '{32'h7fffffff, 32'h7fffffff, 64'h3FFFFFFF00000001, 31};
        vecs[1] = '{32'h00000001, 32'h80000000, 64'hFFFFFFFF80000000, 1};
        vecs[2] = '{32'h7fffffff, 32'hffffffff, 64'hFFFFFFFF80000001, 31};
        vecs[3] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 32};
        vecs[4] = '{32'hffffffff, 32'hffffffff, 64'h0000000000000001, 1};
        vecs[5] = '{32'h00000000, 32'h80000000, 64'h0000000000000000, 1};
        vecs[6] = '{32'h80000000, 32'h00000000, 64'h0000000000000000, 32};
        vecs[7] = '{32'h00000003, 32'hfffffffb, 64'hFFFFFFFFFFFFFFF1, 2};
        vecs[8] = '{32'hffff0000, 32'h00010000, 64'hFFFFFFFF00000000, 17};
        vecs[9] = '{32'h00000011, 32'hfffffffe, 64'hFFFFFFFFFFFFFFDE, 5};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check64("rst_prod_fixed", prodt_f, 64'h0);
        check64("rst_prod_var", prodt_v, 64'h0);
        check_int("rst_valid", int'(valid_f) + int'(valid_v), 0);
        @(negedge clock);
        reset = 1'b1;

        // Directed table; the 5-cycle-low restart is exercised on the last vector
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b, (i == 9) ? 5 : 1);
            collect($sformatf("vec%0d", i), vecs[i].p, vecs[i].lat, (i % 2) == 0);
        end

        // Random operands against a signed 64-bit reference
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = ra >> 20;
            ref_p = longint'($signed(ra)) * longint'($signed(rb));
            launch(ra, rb, 1);
            collect($sformatf("rnd%0d", i), 64'(ref_p), model_lat(ra), 1'b1);
        end

        // Reset during iteration 10 clears outputs at once and aborts the operation
        launch(32'h7fffffff, 32'h00000005, 1);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check64("midrst_prod_fixed", prodt_f, 64'h0);
        check64("midrst_prod_var", prodt_v, 64'h0);
        check_int("midrst_valid", int'(valid_f) + int'(valid_v), 0);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        n_f = 0;
        n_v = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clock);
            #1;
            if (valid_f) n_f++;
            if (valid_v) n_v++;
        end
        check_int("midrst_no_valid_fixed", n_f, 0);
        check_int("midrst_no_valid_var", n_v, 0);

        // start already high when reset releases: first edge is a capture
        @(negedge clock);
        reset = 1'b0;
        mlier = 32'h00000002;
        mcand = 32'h00000003;
        start = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        collect("relstart", 64'h6, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_fl.md
# multi_fl

Sequential signed 32×32→64 multiplier for the datapath arithmetic unit. It uses a radix-2 shift-add array on operand magnitudes, with a final sign correction. Parameter `EARLY_TERM` selects the build:

- `EARLY_TERM=0` gives fixed latency (`multi` role).
- `EARLY_TERM=1` gives variable latency with early termination (`multi_vl` role).

Both builds report a one-cycle `valid` pulse with the product.

## Interface
- `EARLY_TERM`, default 0: 0 = always 32 iterations; 1 = stop once the remaining multiplier magnitude bits are all zero.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mlier`  in  32  multiplier, two's complement; sampled at the start-capture edge only.
- `mcand`  in  32  multiplicand, two's complement; sampled at the start-capture edge only.
- `prodt`  out  64  signed product, two's complement.
- `start`  in  1  level request; an operation begins on its 0→1 transition.
- `valid`  out  1  one-cycle pulse: `prodt` holds the new result.

Port order: `clock`, `reset`, `mlier`, `mcand`, `prodt`, `start`, `valid`.

## Operation
- **States:** IDLE, BUSY.
- **Start edge detection:** an internal register `start_q` tracks `start`. A capture edge is a rising clock with `start=1` and `start_q=0` while in IDLE.
- **Capture (IDLE→BUSY):**
  - Latch `|mlier|` and `|mcand|` as 32-bit unsigned values; `0x80000000` maps to 2^31.
  - Latch `neg = mlier[31] ^ mcand[31]`.
  - Clear the accumulator and set the iteration count to 0.
- **Each BUSY cycle:**
  - If the multiplier LSB is 1, add the shifted multiplicand into the 64-bit accumulator.
  - Shift the multiplier right and the multiplicand left.
  - Increment the count.
- **Finish condition:**
  - `EARLY_TERM=0`: after 32 iterations.
  - `EARLY_TERM=1`: when the shifted multiplier becomes 0 after the current iteration, or after 32 iterations, whichever comes first. A zero multiplier finishes after 1 iteration.
- **Completion:**
  - The same edge that performs the final iteration writes `prodt = neg ? -acc : acc` (64-bit two's complement).
  - It also pulses `valid=1` for one cycle and returns to IDLE.
  - A zero product is always +0.
- **Result hold:** `prodt` holds its value until the next completion.
- **`start` behaviour:**
  - `start` held high after completion does not retrigger; a new operation needs `start` low for at least one cycle.
  - `start` toggling while BUSY is ignored; operand changes while BUSY are ignored.
- **Reset (`reset=0`), asynchronous, including mid-operation:**
  - `prodt=0`, `valid=0`, state IDLE, `start_q=0`, accumulator and counters 0.
  - Any in-flight operation is aborted with no `valid`.
  - If `start` is already high when reset releases, the first active edge is treated as a capture edge.

## Timing
- **Fixed build:** `valid` rises exactly 32 clocks after the capture edge.
- **Variable build:** `valid` rises N clocks after the capture edge, where N = max(1, bit index of the MSB of `|mlier|` + 1).
- **Worst case:** never more than 33 clocks from capture to `valid` in either build.
- **Back-to-back operations:** the earliest next capture is the edge after `valid` (`start` low in between).
- **Outputs:** registered; no combinational path from inputs to outputs.

## Structure
- **Shared package:** `MUL_W = 32`, `PROD_W = 64`, and the IDLE/BUSY state enum.
- **Sub-module:** `mul_abs32` (32-bit two's-complement magnitude, unsigned output). It is instantiated twice at capture.
- **Top level:** the FSM, shift-add datapath, early-termination detect (`EARLY_TERM`-gated) and sign correction stay in one top-level module.

## Test plan
- **Positive × positive:** `0x7fffffff × 0x7fffffff` → `prodt=0x3FFFFFFF00000001`. `valid` at 32 cycles (fixed); at 31 cycles (variable).
- **Mixed signs:**
  - `0x00000001 × 0x80000000` → `0xFFFFFFFF80000000`. Variable latency is 1.
  - `0x7fffffff × 0xffffffff` → `0xFFFFFFFF80000001`.
- **Negative × negative:**
  - `0x80000000 × 0x80000000` → `0x4000000000000000`.
  - `0xffffffff × 0xffffffff` → `0x0000000000000001`.
- **Zero operands:**
  - `0x00000000 × 0x80000000` → 0, with variable latency 1.
  - `0x80000000 × 0x00000000` → 0, with no negative zero.
- **Protocol:**
  - `start` held high for 33 cycles → exactly one `valid` pulse.
  - `start` low for 5 cycles, then high → a new result.
  - `valid` is never later than 33 clocks after capture.
  - Random operands checked against a signed 64-bit reference.
- **Reset:** assert `reset=0` at iteration 10 → `prodt=0` and `valid=0` immediately. No `valid` appears afterward until a new `start` rising edge.
